// File: rtl/epic_racer_pkg.sv
// Shared constants, default sprite bounds and controller state encoding for the racer video path.
package epic_racer_pkg;

   localparam int SCREEN_W  = 1024;
   localparam int SCREEN_H  = 768;
   localparam int SPRITE_SZ = 32;

   localparam int CAR_X_MIN = 0;
   localparam int CAR_X_MAX = SCREEN_W - SPRITE_SZ;
   localparam int CAR_Y_MIN = 0;
   localparam int CAR_Y_MAX = SCREEN_H - SPRITE_SZ;

   typedef enum logic [1:0] {
      CAR_IDLE  = 2'd0,
      CAR_VEL   = 2'd1,
      CAR_POS   = 2'd2,
      CAR_BLINK = 2'd3
   } car_state_e;

   // Per-axis speed limit; boost doubles it.
   function automatic logic [4:0] speed_limit(input int v_max, input logic boost);
      logic [4:0] base;
      base = 5'(v_max);
      if (boost) begin
         speed_limit = base << 1;
      end else begin
         speed_limit = base;
      end
   endfunction

endpackage

// File: rtl/car_position_ctl_axis_motion.sv
// One motion axis: signed velocity with accel/friction/limit and clamped position.
module axis_motion
   import epic_racer_pkg::*;
#(
   parameter int MIN  = CAR_X_MIN,
   parameter int MAX  = CAR_X_MAX,
   parameter int INIT = 384
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   input  logic        dec,
   input  logic [4:0]  vlim,
   input  logic        vel_en,
   input  logic        pos_en,
   output logic [10:0] pos,
   output logic        hit
);

   localparam logic signed [11:0] MIN_S = 12'(MIN);
   localparam logic signed [11:0] MAX_S = 12'(MAX);

   logic signed [4:0]  vel_q, vel_d;
   logic [10:0]        pos_q, pos_d;
   logic               hit_q, hit_d;
   logic signed [5:0]  vel_w, lim_w;
   logic signed [11:0] p_s;

   // Velocity step in VEL, position integrate and clamp in POS.
   always_comb begin
      vel_d = vel_q;
      pos_d = pos_q;
      hit_d = hit_q;
      vel_w = {vel_q[4], vel_q};
      lim_w = {1'b0, vlim};
      p_s   = {1'b0, pos_q} + {{7{vel_q[4]}}, vel_q};
      if (vel_en) begin
         if (inc && !dec) begin
            if (vel_w < lim_w) begin
               vel_d = vel_q + 5'sd1;
            end else if (vel_w > lim_w) begin
               vel_d = vel_q - 5'sd1;
            end else begin
               vel_d = vel_q;
            end
         end else if (dec && !inc) begin
            if (vel_w > -lim_w) begin
               vel_d = vel_q - 5'sd1;
            end else if (vel_w < -lim_w) begin
               vel_d = vel_q + 5'sd1;
            end else begin
               vel_d = vel_q;
            end
         end else begin
            if (vel_q < 5'sd0) begin
               vel_d = vel_q + 5'sd1;
            end else if (vel_q > 5'sd0) begin
               vel_d = vel_q - 5'sd1;
            end else begin
               vel_d = vel_q;
            end
         end
      end else if (pos_en) begin
         if (p_s < MIN_S) begin
            pos_d = MIN_S[10:0];
            vel_d = 5'sd0;
            hit_d = 1'b1;
         end else if (p_s > MAX_S) begin
            pos_d = MAX_S[10:0];
            vel_d = 5'sd0;
            hit_d = 1'b1;
         end else begin
            pos_d = p_s[10:0];
            hit_d = 1'b0;
         end
      end else begin
         vel_d = vel_q;
      end
   end

   // Axis state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         vel_q <= 5'sd0;
         pos_q <= 11'(INIT);
         hit_q <= 1'b0;
      end else begin
         vel_q <= vel_d;
         pos_q <= pos_d;
         hit_q <= hit_d;
      end
   end

   assign pos = pos_q;
   assign hit = hit_q;

endmodule

// File: rtl/car_position_ctl.sv
// Per-frame car sprite position controller, updated once per vsync rising edge.
// Optional boost input and doubled speed limit when CAR_BOOST_EN is defined.
module car_position_ctl
   import epic_racer_pkg::*;
#(
   parameter int X_INIT       = 384,
   parameter int Y_INIT       = 600,
   parameter int X_MIN        = CAR_X_MIN,
   parameter int X_MAX        = CAR_X_MAX,
   parameter int Y_MIN        = CAR_Y_MIN,
   parameter int Y_MAX        = CAR_Y_MAX,
   parameter int V_MAX        = 8,
   parameter int BLINK_FRAMES = 32
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic        vsync_in,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_up,
   input  logic        btn_down,
`ifdef CAR_BOOST_EN
   input  logic        btn_boost,
`endif
   output logic [10:0] xpos,
   output logic [10:0] ypos,
   output logic        visible
);

   car_state_e  state_q, state_d;
   logic        vsync_q;
   logic        tick;
   logic [5:0]  blink_q, blink_d;
   logic        visible_q, visible_d;
   logic [4:0]  vlim;
   logic        hit_x, hit_y;
   logic        vel_en, pos_en;

   assign tick   = vsync_in & ~vsync_q;
   assign vel_en = (state_q == CAR_VEL);
   assign pos_en = (state_q == CAR_POS);

`ifdef CAR_BOOST_EN
   assign vlim = speed_limit(V_MAX, btn_boost);
`else
   assign vlim = speed_limit(V_MAX, 1'b0);
`endif

   // Frame update sequencer.
   always_comb begin
      state_d = state_q;
      case (state_q)
         CAR_IDLE: begin
            if (tick) begin
               state_d = CAR_VEL;
            end else begin
               state_d = CAR_IDLE;
            end
         end
         CAR_VEL:   state_d = CAR_POS;
         CAR_POS:   state_d = CAR_BLINK;
         CAR_BLINK: state_d = CAR_IDLE;
         default:   state_d = CAR_IDLE;
      endcase
   end

   // Crash blink: any hit restarts the count; hidden while count bit 2 is set.
   always_comb begin
      blink_d   = blink_q;
      visible_d = visible_q;
      if (state_q == CAR_BLINK) begin
         if (hit_x || hit_y) begin
            blink_d = 6'(BLINK_FRAMES);
         end else if (blink_q != 6'd0) begin
            blink_d = blink_q - 6'd1;
         end else begin
            blink_d = blink_q;
         end
         visible_d = (blink_d == 6'd0) | ~blink_d[2];
      end else begin
         blink_d   = blink_q;
         visible_d = visible_q;
      end
   end

   // Control registers.
   always_ff @(posedge pclk) begin
      if (rst) begin
         state_q   <= CAR_IDLE;
         vsync_q   <= 1'b1;
         blink_q   <= 6'd0;
         visible_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         vsync_q   <= vsync_in;
         blink_q   <= blink_d;
         visible_q <= visible_d;
      end
   end

   axis_motion #(.MIN(X_MIN), .MAX(X_MAX), .INIT(X_INIT)) u_axis_x (
      .clk    (pclk),
      .rst    (rst),
      .inc    (btn_right),
      .dec    (btn_left),
      .vlim   (vlim),
      .vel_en (vel_en),
      .pos_en (pos_en),
      .pos    (xpos),
      .hit    (hit_x)
   );

   axis_motion #(.MIN(Y_MIN), .MAX(Y_MAX), .INIT(Y_INIT)) u_axis_y (
      .clk    (pclk),
      .rst    (rst),
      .inc    (btn_down),
      .dec    (btn_up),
      .vlim   (vlim),
      .vel_en (vel_en),
      .pos_en (pos_en),
      .pos    (ypos),
      .hit    (hit_y)
   );

   assign visible = visible_q;

endmodule

// File: tb/tb_car_position_ctl.sv
// Randomized bench for car_position_ctl against a frame-level behavioural model.
module tb_car_position_ctl;

`ifdef CAR_BOOST_EN
   localparam int VMAX = 7;
`else
   localparam int VMAX = 8;
`endif
   localparam int XMAX = 992;
   localparam int YMAX = 736;

   logic        pclk = 1'b0;
   logic        rst;
   logic        vsync_in;
   logic        bl, br, bu, bd, bb;
   logic [10:0] xpos, ypos;
   logic        visible;

   int n_checks = 0;
   int n_errors = 0;
   int m_x, m_y, m_vx, m_vy, m_blink, m_vis;

   always #5 pclk = ~pclk;

   car_position_ctl #(.V_MAX(VMAX)) dut (
      .pclk      (pclk),
      .rst       (rst),
      .vsync_in  (vsync_in),
      .btn_left  (bl),
      .btn_right (br),
      .btn_up    (bu),
      .btn_down  (bd),
`ifdef CAR_BOOST_EN
      .btn_boost (bb),
`endif
      .xpos      (xpos),
      .ypos      (ypos),
      .visible   (visible)
   );

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int toward(input int v, input int tgt);
      return (v < tgt) ? v + 1 : (v > tgt) ? v - 1 : v;
   endfunction

   task automatic model_reset();
      m_x = 384; m_y = 600; m_vx = 0; m_vy = 0; m_blink = 0; m_vis = 1;
   endtask

   task automatic model_frame(input logic l, input logic r, input logic u, input logic d, input logic b);
      int lim, px, py;
      bit hit;
`ifdef CAR_BOOST_EN
      lim = b ? 2 * VMAX : VMAX;
`else
      lim = VMAX;
`endif
      m_vx = toward(m_vx, (r && !l) ? lim : (l && !r) ? -lim : 0);
      m_vy = toward(m_vy, (d && !u) ? lim : (u && !d) ? -lim : 0);
      hit = 1'b0;
      px = m_x + m_vx;
      py = m_y + m_vy;
      if (px < 0) begin m_x = 0; m_vx = 0; hit = 1'b1; end
      else if (px > XMAX) begin m_x = XMAX; m_vx = 0; hit = 1'b1; end
      else m_x = px;
      if (py < 0) begin m_y = 0; m_vy = 0; hit = 1'b1; end
      else if (py > YMAX) begin m_y = YMAX; m_vy = 0; hit = 1'b1; end
      else m_y = py;
      if (hit) m_blink = 32;
      else if (m_blink > 0) m_blink--;
      m_vis = (m_blink == 0 || (m_blink % 8) < 4) ? 1 : 0;
   endtask

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   // One full frame: tick, update pipeline checks, hold check, vsync low.
   task automatic run_frame(input logic l, input logic r, input logic u, input logic d, input logic b);
      int ox, oy, ov;
      ox = m_x; oy = m_y; ov = m_vis;
      {bl, br, bu, bd, bb} = {l, r, u, d, b};
      vsync_in = 1'b1;
      step();
      check_val("x_at_e0", int'(xpos), ox);
      step();
      {bl, br, bu, bd, bb} = 5'($urandom);
      model_frame(l, r, u, d, b);
      check_val("x_at_e1", int'(xpos), ox);
      check_val("y_at_e1", int'(ypos), oy);
      step();
      check_val("x_at_e2", int'(xpos), m_x);
      check_val("y_at_e2", int'(ypos), m_y);
      check_val("vis_at_e2", int'(visible), ov);
      step();
      check_val("vis_at_e3", int'(visible), m_vis);
      repeat (3) step();
      check_val("x_hold", int'(xpos), m_x);
      check_val("y_hold", int'(ypos), m_y);
      check_val("vis_hold", int'(visible), m_vis);
      vsync_in = 1'b0;
      repeat (3) step();
   endtask

   initial begin
      int prev, frames;
      logic [4:0] pat;
      rst = 1'b1; vsync_in = 1'b1; {bl, br, bu, bd, bb} = 5'd0;
      model_reset();
      repeat (3) step();
      rst = 1'b0;
      repeat (4) step();
      check_val("reset_x", int'(xpos), 384);
      check_val("reset_y", int'(ypos), 600);
      check_val("reset_vis", int'(visible), 1);
      vsync_in = 1'b0;
      repeat (2) step();

      repeat (10) run_frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
`ifndef CAR_BOOST_EN
      check_val("accel_x", int'(xpos), 436);
`endif
      repeat (4) run_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (4) run_frame(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
`ifndef CAR_BOOST_EN
      check_val("decay_x", int'(xpos), 464);
`endif

`ifdef CAR_BOOST_EN
      repeat (20) run_frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      prev = int'(xpos);
      run_frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      check_val("boost_sat", int'(xpos) - prev, 14);
      for (int k = 13; k >= 7; k--) begin
         prev = int'(xpos);
         run_frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         check_val("boost_decay", int'(xpos) - prev, k);
      end
      prev = int'(xpos);
      run_frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_val("boost_floor", int'(xpos) - prev, 7);
`endif

      frames = 0;
      while (m_x != 0 && frames < 300) begin
         run_frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         frames++;
      end
      check_val("clamp_left_x", int'(xpos), 0);
      repeat (40) run_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_val("blink_end_vis", int'(visible), 1);

      {bl, br, bu, bd, bb} = 5'b01010;
      vsync_in = 1'b1;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      model_reset();
      check_val("midrst_x", int'(xpos), 384);
      check_val("midrst_y", int'(ypos), 600);
      check_val("midrst_vis", int'(visible), 1);
      repeat (3) step();
      check_val("midrst_notick", int'(xpos), 384);
      vsync_in = 1'b0;
      repeat (2) step();
      run_frame(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      check_val("fresh_x", int'(xpos), 385);
      check_val("fresh_y", int'(ypos), 601);

      pat = 5'($urandom);
      for (int f = 0; f < 250; f++) begin
         if ($urandom_range(3, 0) == 0) pat = 5'($urandom);
         run_frame(pat[4], pat[3], pat[2], pat[1], pat[0]);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/car_position_ctl.md
# car_position_ctl

Per-frame sprite position controller for the player car. Samples the driving buttons once per frame at the rising edge of vsync, integrates a signed velocity with acceleration, friction and clamping, and drives the `xpos`/`ypos`/`visible` inputs of the downstream 32x32 sprite draw stage. Outputs are held constant for the whole active frame, so the draw stage never sees a mid-frame jump.

## Interface
Parameters:
- `X_INIT`, 384: reset x position.
- `Y_INIT`, 600: reset y position.
- `X_MIN`, 0: lower bound for `xpos`.
- `X_MAX`, 992: upper bound for `xpos` (1024-32).
- `Y_MIN`, 0: lower bound for `ypos`.
- `Y_MAX`, 736: upper bound for `ypos` (768-32).
- `V_MAX`, 8: speed limit per axis, in pixels/frame; must be ≤ 15.
- `BLINK_FRAMES`, 32: crash blink duration in frames; must be ≤ 63.

Ports:
- `pclk` in 1: pixel clock, the only clock.
- `rst` in 1: synchronous, active-high reset.
- `vsync_in` in 1: vsync from the timing chain.
- `btn_left`, `btn_right`, `btn_up`, `btn_down` in 1 each: debounced, level-sensitive buttons.
- `btn_boost` in 1: present only when `CAR_BOOST_EN` is defined.
- `xpos` out 11: sprite x position.
- `ypos` out 11: sprite y position.
- `visible` out 1: sprite enable.

## Operation
- Frame tick: `tick = vsync_in & ~vsync_q`, where `vsync_q` is the registered `vsync_in`. `vsync_q` resets to 1, so a high `vsync_in` at reset release does not produce a tick.
- FSM states: IDLE, VEL, POS, BLINK.
  - IDLE → VEL on tick.
  - VEL → POS unconditionally.
  - POS → BLINK unconditionally.
  - BLINK → IDLE unconditionally.
  - A tick seen outside IDLE is ignored. This cannot occur at legal vsync rates.
- VEL, per axis (x: right = +, left = −; y: down = +, up = −). Velocity is 5-bit signed (`vx`, `vy`).
  - Exactly one direction button pressed: step velocity by ±1 toward that direction, saturating at ±V_MAX.
  - Both or neither pressed: decay velocity by 1 toward 0; 0 stays 0.
  - Opposite-direction press from a nonzero velocity decelerates by 1 per frame; there is no instant reversal.
- POS, per axis:
  - Compute `p = pos + sext(v)` in 12-bit signed.
  - If `p < MIN`: `pos = MIN`, `v = 0`, set hit.
  - Else if `p > MAX`: `pos = MAX`, `v = 0`, set hit.
  - Else: `pos = p[10:0]`.
- BLINK:
  - On any hit (x or y), load `blink_cnt = BLINK_FRAMES`, restarting an active blink.
  - Otherwise, if `blink_cnt != 0`, decrement it.
  - `visible = (blink_cnt == 0) | ~blink_cnt[2]`, evaluated on the updated count. The sprite is hidden for 4 frames out of every 8 while blinking.
- Reset, including mid-update: FSM to IDLE; `xpos = X_INIT`, `ypos = Y_INIT`, `visible = 1`, `vx = vy = 0`, `blink_cnt = 0`, `vsync_q = 1`.

## Timing
- Edge E0 samples the tick.
- E1 (VEL): velocities registered.
- E2 (POS): `xpos`/`ypos` registered. They are visible 2 cycles after E0.
- E3 (BLINK): `visible` registered, 3 cycles after E0.
- All outputs are stable from E3 until the next tick. Vsync is far longer than 3 cycles, so updates complete inside vertical blanking.
- Buttons are sampled only at E1 (VEL). Presses shorter than one frame that miss E1 are lost by design.

## Configuration
- Macro: `CAR_BOOST_EN`.
- Defined:
  - `btn_boost` port exists.
  - While `btn_boost` = 1 at E1, the saturation limit is `2*V_MAX`, so V_MAX must be ≤ 7.
  - On boost release, velocity above V_MAX decays by 1 per frame; it is not clipped immediately.
- Undefined:
  - No `btn_boost` port.
  - Limit is fixed at V_MAX.

## Structure
- Shared package `epic_racer_pkg` holds:
  - Screen constants: 1024, 768, sprite size 32.
  - Default bounds.
  - The FSM state encoding (`CAR_IDLE`, `CAR_VEL`, `CAR_POS`, `CAR_BLINK`).
- One sub-module, `axis_motion`, instantiated twice (x, y).
  - Parameterised by MIN, MAX, INIT.
  - Inputs: `inc`, `dec`, `vlim`, `vel_en`, `pos_en`.
  - Outputs: `pos`, `hit`.
  - Holds that axis's velocity and position registers.

## Test plan
- Reset with `vsync_in` held high, then release → no update: `xpos` = 384, `ypos` = 600, `visible` = 1.
- `btn_right` held for 10 ticks → `vx` reaches 8. `xpos` = 384 + (1+2+…+8) + 8 + 8 = 436. `xpos` changes exactly 2 cycles after each tick edge.
- Release after that → `vx` decays 7, 6, …, 0 over 8 ticks; `xpos` ends at 436 + 28 = 464. Both left and right held gives the same decay.
- `btn_left` held from `xpos` = 4 → `xpos` = 3, then clamps at 0. On clamp: `vx` = 0, `visible` toggles 4 frames low / 4 high for 32 frames, then stays 1.
- Assert `rst` during POS (cycle E2) → next cycle outputs are 384 / 600 / 1 and the FSM is in IDLE. The next tick behaves as a fresh start.
- With `CAR_BOOST_EN` and V_MAX = 7: hold `btn_right` + `btn_boost` → `vx` saturates at 14. Release boost → `vx` steps 13, 12, … down to 7 while `btn_right` stays held.
